// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard. Issue logic
// marks producers busy, writeback clears them, and reads can bypass same-cycle writes.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic [NREAD-1:0]        rbusy,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    wa,
    input  logic [NWRITE*WIDTH-1:0] wd,
    input  logic                    set_en,
    input  logic [AW-1:0]           set_addr,
    output logic [DEPTH-1:0]        busy_vec
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next state of storage and scoreboard; ascending port order lets the highest port win
    always_comb begin
        logic [AW-1:0] waddr;
        waddr  = '0;
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            waddr = wa[j*AW +: AW];
            if (we[j] && !(ZERO_REG && (waddr == '0))) begin
                mem_d[waddr] = wd[j*WIDTH +: WIDTH];
            end else begin
                mem_d[waddr] = mem_d[waddr];
            end
            if (we[j]) begin
                busy_d[waddr] = 1'b0;
            end else begin
                busy_d[waddr] = busy_d[waddr];
            end
        end
        // A newly issued producer supersedes the one completing this cycle
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end else begin
            busy_d[set_addr] = busy_d[set_addr];
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end else begin
            busy_d[0] = busy_d[0];
        end
    end

    // Storage and scoreboard state, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports with optional write bypass and forced zeros
    always_comb begin
        logic [AW-1:0]    raddr;
        logic [WIDTH-1:0] data;
        logic             bsy;
        raddr = '0;
        data  = '0;
        bsy   = 1'b0;
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            raddr = ra[i*AW +: AW];
            data  = mem_q[raddr];
            bsy   = busy_q[raddr];
            for (int j = 0; j < NWRITE; j++) begin
                if (BYPASS && we[j] && (wa[j*AW +: AW] == raddr)) begin
                    data = wd[j*WIDTH +: WIDTH];
                    bsy  = 1'b0;
                end else begin
                    data = data;
                    bsy  = bsy;
                end
            end
            if (reset || (ZERO_REG && (raddr == '0))) begin
                data = '0;
                bsy  = 1'b0;
            end else begin
                data = data;
                bsy  = bsy;
            end
            rd[i*WIDTH +: WIDTH] = data;
            rbusy[i]             = bsy;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios on two 32x32 configurations
// and a randomised sweep of a 16x8, 4-read, 2-write configuration against a model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;

    // dut_a: defaults (zero register, no bypass), one write port
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic [0:0]  a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        a_set_en;
    logic [4:0]  a_set_addr;
    logic [31:0] a_busy_vec;
    // dut_b: no zero register, bypass, two write ports
    logic [9:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_rbusy;
    logic [1:0]  b_we;
    logic [9:0]  b_wa;
    logic [63:0] b_wd;
    logic        b_set_en;
    logic [4:0]  b_set_addr;
    logic [31:0] b_busy_vec;
    // dut_c: sweep configuration
    logic [11:0] c_ra;
    logic [63:0] c_rd;
    logic [3:0]  c_rbusy;
    logic [1:0]  c_we;
    logic [5:0]  c_wa;
    logic [31:0] c_wd;
    logic        c_set_en;
    logic [2:0]  c_set_addr;
    logic [7:0]  c_busy_vec;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(1), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_a (
        .clk(clk), .reset(reset), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy), .we(a_we), .wa(a_wa),
        .wd(a_wd), .set_en(a_set_en), .set_addr(a_set_addr), .busy_vec(a_busy_vec));

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy), .we(b_we), .wa(b_wa),
        .wd(b_wd), .set_en(b_set_en), .set_addr(b_set_addr), .busy_vec(b_busy_vec));

    regfile_mp #(.WIDTH(16), .DEPTH(8), .NREAD(4), .NWRITE(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .ra(c_ra), .rd(c_rd), .rbusy(c_rbusy), .we(c_we), .wa(c_wa),
        .wd(c_wd), .set_en(c_set_en), .set_addr(c_set_addr), .busy_vec(c_busy_vec));

    task automatic idle_wr();
        a_we = 1'b0; a_wa = '0; a_wd = '0; a_set_en = 1'b0; a_set_addr = '0;
        b_we = 2'b00; b_wa = '0; b_wd = '0; b_set_en = 1'b0; b_set_addr = '0;
        c_we = 2'b00; c_wa = '0; c_wd = '0; c_set_en = 1'b0; c_set_addr = '0;
    endtask

    task automatic test_reset();
        a_ra = {5'd7, 5'd5}; b_ra = '0; c_ra = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rd) !== exp_v) begin bad++; $display("FAIL reset_rd got=%h want=%h", a_rd, exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rbusy) !== exp_v) begin bad++; $display("FAIL reset_rbusy got=%h want=%h", a_rbusy, exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_busy_vec) !== exp_v) begin bad++; $display("FAIL reset_busy_a got=%h want=%h", a_busy_vec, exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(c_busy_vec) !== exp_v) begin bad++; $display("FAIL reset_busy_c got=%h want=%h", c_busy_vec, exp_v); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF; a_set_en = 1'b1; a_set_addr = 5'd7;
        exp_q.push_back(64'h00000000DEADBEEF); exp_q.push_back(64'd2);
        @(posedge clk); #1 idle_wr();
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rd[31:0]) !== exp_v) begin bad++; $display("FAIL pre_reset_rd got=%h want=%h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rbusy) !== exp_v) begin bad++; $display("FAIL pre_reset_rbusy got=%h want=%h", a_rbusy, exp_v); end
        // Reset pulse between edges must act without a clock
        #2 reset = 1'b1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rd[31:0]) !== exp_v) begin bad++; $display("FAIL midreset_rd got=%h want=%h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_busy_vec) !== exp_v) begin bad++; $display("FAIL midreset_busy got=%h want=%h", a_busy_vec, exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rbusy) !== exp_v) begin bad++; $display("FAIL midreset_rbusy got=%h want=%h", a_rbusy, exp_v); end
        reset = 1'b0;
        exp_q.push_back(64'd0);
        @(negedge clk);
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rd[31:0]) !== exp_v) begin bad++; $display("FAIL post_reset_rd got=%h want=%h", a_rd[31:0], exp_v); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'h12345678; a_set_en = 1'b1; a_set_addr = 5'd0;
        b_we = 2'b01; b_wa = '0; b_wd = {32'd0, 32'h12345678}; b_set_en = 1'b1; b_set_addr = 5'd0;
        a_ra = '0; b_ra = '0;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        exp_q.push_back(64'h0000000012345678); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
        @(posedge clk); #1 idle_wr();
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rd[31:0]) !== exp_v) begin bad++; $display("FAIL zero_rd_a got=%h want=%h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_busy_vec[0]) !== exp_v) begin bad++; $display("FAIL zero_busy_a got=%h want=%h", a_busy_vec[0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_rd[31:0]) !== exp_v) begin bad++; $display("FAIL zero_rd_b got=%h want=%h", b_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_busy_vec[0]) !== exp_v) begin bad++; $display("FAIL zero_busy_b got=%h want=%h", b_busy_vec[0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_rbusy[0]) !== exp_v) begin bad++; $display("FAIL zero_rbusy_b got=%h want=%h", b_rbusy[0], exp_v); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        b_we = 2'b11; b_wa = {5'd3, 5'd3}; b_wd = {32'h00005555, 32'h0000AAAA}; b_ra = {5'd0, 5'd3};
        exp_q.push_back(64'h5555); exp_q.push_back(64'h5555);
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_rd[31:0]) !== exp_v) begin bad++; $display("FAIL collide_bypass got=%h want=%h", b_rd[31:0], exp_v); end
        @(posedge clk); #1 idle_wr();
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_rd[31:0]) !== exp_v) begin bad++; $display("FAIL collide_stored got=%h want=%h", b_rd[31:0], exp_v); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'd1; a_set_en = 1'b1; a_set_addr = 5'd9;
        b_we = 2'b01; b_wa = {5'd0, 5'd9}; b_wd = {32'd0, 32'd1}; b_set_en = 1'b1; b_set_addr = 5'd9;
        @(posedge clk); #1 idle_wr();
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'd2; a_ra = {5'd0, 5'd9};
        b_we = 2'b01; b_wa = {5'd0, 5'd9}; b_wd = {32'd0, 32'd2}; b_ra = {5'd0, 5'd9};
        b_set_en = 1'b1; b_set_addr = 5'd9;
        exp_q.push_back(64'd2); exp_q.push_back(64'd0); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_rd[31:0]) !== exp_v) begin bad++; $display("FAIL bypass_rd_b got=%h want=%h", b_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_rbusy[0]) !== exp_v) begin bad++; $display("FAIL bypass_rbusy_b got=%h want=%h", b_rbusy[0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rd[31:0]) !== exp_v) begin bad++; $display("FAIL nobypass_rd_a got=%h want=%h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rbusy[0]) !== exp_v) begin bad++; $display("FAIL nobypass_rbusy_a got=%h want=%h", a_rbusy[0], exp_v); end
        exp_q.push_back(64'd2); exp_q.push_back(64'd0); exp_q.push_back(64'd1);
        @(posedge clk); #1 idle_wr();
        #1;
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rd[31:0]) !== exp_v) begin bad++; $display("FAIL after_rd_a got=%h want=%h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_rbusy[0]) !== exp_v) begin bad++; $display("FAIL after_rbusy_a got=%h want=%h", a_rbusy[0], exp_v); end
        exp_v = exp_q.pop_front(); total++;
        if (64'(b_busy_vec[9]) !== exp_v) begin bad++; $display("FAIL after_set_b got=%h want=%h", b_busy_vec[9], exp_v); end
    endtask

    task automatic test_race();
        @(negedge clk);
        a_set_en = 1'b1; a_set_addr = 5'd4;
        @(posedge clk); #1 idle_wr();
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd4; a_wd = 32'd7; a_set_en = 1'b1; a_set_addr = 5'd4;
        exp_q.push_back(64'd1);
        @(posedge clk); #1 idle_wr();
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_busy_vec[4]) !== exp_v) begin bad++; $display("FAIL race_set_wins got=%h want=%h", a_busy_vec[4], exp_v); end
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd4; a_wd = 32'd8;
        exp_q.push_back(64'd0);
        @(posedge clk); #1 idle_wr();
        exp_v = exp_q.pop_front(); total++;
        if (64'(a_busy_vec[4]) !== exp_v) begin bad++; $display("FAIL race_clear got=%h want=%h", a_busy_vec[4], exp_v); end
    endtask

    task automatic test_sweep();
        logic [15:0] m_mem [8];
        logic [7:0]  m_busy;
        logic [63:0] e_rd;
        logic [3:0]  e_rbusy;
        logic [31:0] rnd;
        logic [2:0]  ad;
        logic [15:0] dv;
        logic        bv;
        for (int r = 0; r < 8; r++) m_mem[r] = 16'd0;
        m_busy = 8'd0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            rnd = $urandom; c_ra = rnd[11:0]; c_we = rnd[13:12]; c_set_en = rnd[14]; c_set_addr = rnd[17:15];
            c_wa = rnd[23:18];
            rnd = $urandom; c_wd = rnd;
            e_rd = '0; e_rbusy = '0;
            for (int i = 0; i < 4; i++) begin
                ad = c_ra[i*3 +: 3];
                dv = m_mem[ad];
                bv = m_busy[ad];
                for (int j = 0; j < 2; j++) begin
                    if (c_we[j] && c_wa[j*3 +: 3] == ad) begin dv = c_wd[j*16 +: 16]; bv = 1'b0; end
                end
                if (ad == 3'd0) begin dv = 16'd0; bv = 1'b0; end
                e_rd[i*16 +: 16] = dv;
                e_rbusy[i] = bv;
            end
            exp_q.push_back(e_rd); exp_q.push_back(64'(e_rbusy)); exp_q.push_back(64'(m_busy));
            #1;
            exp_v = exp_q.pop_front(); total++;
            if (c_rd !== exp_v) begin bad++; $display("FAIL sweep_rd cyc=%0d got=%h want=%h", cyc, c_rd, exp_v); end
            exp_v = exp_q.pop_front(); total++;
            if (64'(c_rbusy) !== exp_v) begin bad++; $display("FAIL sweep_rbusy cyc=%0d got=%h want=%h", cyc, c_rbusy, exp_v); end
            exp_v = exp_q.pop_front(); total++;
            if (64'(c_busy_vec) !== exp_v) begin bad++; $display("FAIL sweep_busy cyc=%0d got=%h want=%h", cyc, c_busy_vec, exp_v); end
            // Reference update applied at the coming edge
            for (int j = 0; j < 2; j++) begin
                if (c_we[j]) begin
                    ad = c_wa[j*3 +: 3];
                    if (ad != 3'd0) m_mem[ad] = c_wd[j*16 +: 16];
                    m_busy[ad] = 1'b0;
                end
            end
            if (c_set_en && c_set_addr != 3'd0) m_busy[c_set_addr] = 1'b1;
            @(posedge clk);
        end
        #1 idle_wr();
    endtask

    initial begin
        idle_wr();
        test_reset();
        test_zero_reg();
        test_collision();
        test_bypass();
        test_race();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
